read_port_arbiter: RTL
======================

Name: read_port_arbiter

Overview:
Shares the single 4-row read port (one-hot rwl_0..rwl_3 driving the 4:1 read mux, 1-bit DOUT) between NREQ requesters. Round-robin arbitration picks a requester. The block holds the selected wordline for a fixed number of cycles, samples the mux output and returns it with a valid pulse. Guarantees strictly one-hot wordlines with a break-before-make gap between reads. Sits between the bank's client logic and the read mux.

Parameters:
NREQ, 4, number of requesters (2..8)
RWL_CYCLES, 2, cycles a wordline is held high before DOUT is sampled (>=1)
GAP_CYCLES, 1, all-wordlines-low cycles after each read (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester read request, level, held until own rvalid
addr  input  2*NREQ  row address per requester, requester i at [2i+1:2i]
gnt  output  NREQ  one-cycle pulse: request i accepted, addr captured
rvalid  output  NREQ  one-cycle pulse: rdata valid for requester i
rdata  output  1  read data, held until next capture
rwl_0..rwl_3  output  1 each  read wordlines to the read mux, one-hot or all zero
dout  input  1  read mux output (DOUT)

Behaviour:
- Reset (async, immediate): all rwl_* = 0, gnt = 0, rvalid = 0, rdata = 0, state = IDLE, RR pointer = NREQ-1 (requester 0 has top priority first).
- FSM states: IDLE, WL, GAP.
- IDLE:
  - If req != 0, the arbiter picks the winner: first set req bit searching from pointer+1 upward, with wrap-around.
  - On the clock edge: latch winner index and addr[winner], set pointer = winner, go to WL.
  - If req == 0, stay in IDLE.
- WL: lasts exactly RWL_CYCLES cycles.
  - rwl_<addr> = 1 from the first WL cycle; other rwl_* = 0.
  - gnt[winner] pulses high in the first WL cycle only.
  - At the edge ending the last WL cycle: rdata <= dout, go to GAP.
- GAP: lasts exactly GAP_CYCLES cycles.
  - All rwl_* = 0.
  - rvalid[winner] pulses high in the first GAP cycle only.
  - Then go to IDLE.
- All outputs are registered. No combinational path from req/addr to outputs.
- Latency: req sampled in IDLE -> rvalid 1+RWL_CYCLES cycles later.
- Throughput: one read per 1+RWL_CYCLES+GAP_CYCLES cycles (4 with defaults).
- Requester contract:
  - addr stable from req rise until gnt.
  - req must drop in the cycle after rvalid, or it is treated as a new request.
- Request withdrawn before gnt: simply not considered. After gnt: ignored, the transaction completes.
- Simultaneous requests: RR order. Requester i wins again only after every other pending requester has been served.
- Reset mid-operation: wordline drops immediately and no rvalid is issued. A requester that still holds req is re-arbitrated after reset release.
- Invariant: never more than one rwl_* high. At least GAP_CYCLES all-low cycles between any two wordline activations, even for the same row.

Optional Feature:
READ_PORT_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins. Pointer logic is removed.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Decomposition:
- Package read_port_pkg:
  - state enum {IDLE, WL, GAP}
  - ROW_W = 2, NROW = 4
  - counter width from max(RWL_CYCLES, GAP_CYCLES)
- Sub-module rr_arbiter:
  - Inputs: req vector, pointer. Output: one-hot grant.
  - Combinational. Replaced by a priority encoder under READ_PORT_FIXED_PRIO_EN.
- The FSM, cycle counter and rwl decoder stay in read_port_arbiter.

Test Plan (defaults):
- Reset then idle: rst pulse, req=0 -> all rwl_*, gnt, rvalid, rdata = 0 indefinitely.
- Single read: req=4'b0001, addr0=2, dout=1 during WL.
  - Next cycle: rwl_2=1 for 2 cycles, gnt[0] in the first of them.
  - Following cycle: rwl all 0, rvalid[0]=1, rdata=1.
- Contention: req=4'b1011 held, all addr=1, each requester drops req after its rvalid.
  - gnt order 0,1,3, each 4 cycles apart.
  - rwl_1 pulses separated by 2 low cycles (GAP plus IDLE).
- Back-to-back same row: req0 addr=3, then req1 addr=3 -> rwl_3 falls for >=1 cycle between activations, never merged.
- Async reset during WL: rst asserted mid-cycle with rwl_1=1 -> rwl_1=0 before the next edge, no rvalid.
  - After release, a held req is re-served with a full WL/GAP sequence.
- Fixed priority (READ_PORT_FIXED_PRIO_EN): req=4'b0011 held continuously -> requester 0 granted every 4 cycles, requester 1 starved.

Source files
------------

// File: rtl/read_port_arbiter_pkg.sv
// Shared types and helpers for the 4-row read port arbiter.
package read_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WL   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned ROW_W = 2;
  localparam int unsigned NROW  = 4;

  // Phase counter only needs to reach max(RWL_CYCLES, GAP_CYCLES) - 1.
  function automatic int unsigned cnt_width(input int unsigned rwl_cycles,
                                            input int unsigned gap_cycles);
    int unsigned longest;
    longest = (rwl_cycles > gap_cycles) ? rwl_cycles : gap_cycles;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

  // Row index to one-hot wordline vector.
  function automatic logic [NROW-1:0] row_decode(input logic [ROW_W-1:0] row);
    return NROW'(1) << row;
  endfunction

endpackage

// File: rtl/read_port_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr+1 upward with wrap,
// or lowest-index-wins when READ_PORT_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
`ifndef READ_PORT_FIXED_PRIO_EN
  input  logic [$clog2(NREQ)-1:0] ptr,
`endif
  output logic [NREQ-1:0]         grant
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic found;

`ifdef READ_PORT_FIXED_PRIO_EN
  // Lowest set request bit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[IDX_W'(k)]) begin
        grant[IDX_W'(k)] = 1'b1;
        found            = 1'b1;
      end
    end
  end
`else
  int unsigned idx;

  // First set request bit after the last winner, wrapping around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        found              = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/read_port_arbiter.sv
// Shares the single 4-row read port between NREQ requesters: picks a winner,
// holds its wordline for RWL_CYCLES, samples dout, then forces GAP_CYCLES of
// all-low wordlines before the next read.
// Optional: READ_PORT_FIXED_PRIO_EN selects fixed lowest-index priority.
module read_port_arbiter
  import read_port_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned RWL_CYCLES = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   addr,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rvalid,
  output logic                rdata,
  output logic                rwl_0,
  output logic                rwl_1,
  output logic                rwl_2,
  output logic                rwl_3,
  input  logic                dout
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = cnt_width(RWL_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] RWL_LAST = CNT_W'(RWL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] win, win_n;
  logic [ROW_W-1:0] row, row_n;
  logic [NROW-1:0]  rwl, rwl_n;
  logic [NREQ-1:0]  gnt_n, rvalid_n;
  logic             rdata_n;

  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic [ROW_W-1:0] pick_row;

`ifndef READ_PORT_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr, ptr_n;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req),
`ifndef READ_PORT_FIXED_PRIO_EN
    .ptr   (ptr),
`endif
    .grant (pick)
  );

  // One-hot grant to winner index and its row address.
  always_comb begin
    pick_idx = '0;
    pick_row = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[IDX_W'(i)]) begin
        pick_idx = IDX_W'(i);
        pick_row = addr[i*ROW_W +: ROW_W];
      end
    end
  end

  // Next-state and next-output logic; wordlines default low every cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    win_n    = win;
    row_n    = row;
    rwl_n    = '0;
    gnt_n    = '0;
    rvalid_n = '0;
    rdata_n  = rdata;
`ifndef READ_PORT_FIXED_PRIO_EN
    ptr_n    = ptr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          win_n   = pick_idx;
          row_n   = pick_row;
`ifndef READ_PORT_FIXED_PRIO_EN
          ptr_n   = pick_idx;
`endif
          cnt_n   = '0;
          rwl_n   = row_decode(pick_row);
          gnt_n   = pick;
          state_n = WL;
        end
      end
      WL: begin
        if (cnt == RWL_LAST) begin
          rdata_n  = dout;
          rvalid_n = NREQ'(1) << win;
          cnt_n    = '0;
          state_n  = GAP;
        end else begin
          rwl_n = row_decode(row);
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the wordline immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      win    <= '0;
      row    <= '0;
      rwl    <= '0;
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      win    <= win_n;
      row    <= row_n;
      rwl    <= rwl_n;
      gnt    <= gnt_n;
      rvalid <= rvalid_n;
      rdata  <= rdata_n;
    end
  end

`ifndef READ_PORT_FIXED_PRIO_EN
  // Round-robin pointer; starts at NREQ-1 so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(NREQ - 1);
    end else begin
      ptr <= ptr_n;
    end
  end
`endif

  assign rwl_0 = rwl[0];
  assign rwl_1 = rwl[1];
  assign rwl_2 = rwl[2];
  assign rwl_3 = rwl[3];

endmodule
